// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word-aligned requests under a credit
// limit, buffers in-order responses in a small FIFO and handles redirects from execute.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
  parameter int              DEPTH    = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t DEPTH_C = CW'(DEPTH);

  // Handshakes: a transfer happens on a cycle where valid && ready at the rising edge;
  // valid never depends on ready, and request address is held while valid && !ready.
  // The response channel is valid-only: the credit rule below reserves a FIFO slot
  // for every useful in-flight request, so responses never need backpressure.

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rsp_pc;
  cnt_t            outstanding;
  cnt_t            drop;
  cnt_t            count;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [31:0]     mem_inst [DEPTH];
  logic [XLEN-1:0] mem_pc   [DEPTH];

  logic            req_fire;
  logic            rsp_ok;
  logic            rsp_drop;
  logic            push;
  logic            pop;
  logic [CW:0]     credits_used;
  logic [XLEN-1:0] redirect_base;
  logic            unused_lsb;

  assign redirect_base = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_lsb    = ^redirect_pc[1:0];

  // Useful in-flight requests plus buffered entries must stay below DEPTH to issue.
  assign credits_used   = {1'b0, outstanding} - {1'b0, drop} + {1'b0, count};
  assign imem_req_valid = reset_n && !redirect_valid && (credits_used < {1'b0, DEPTH_C});
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_ok   = imem_rsp_valid && (outstanding != '0);
  assign rsp_drop = rsp_ok && (drop != '0);
  assign push     = rsp_ok && (drop == '0) && !redirect_valid;
  assign pop      = inst_valid && inst_ready && !redirect_valid;

  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? mem_inst[rd_ptr] : 32'h0;
  assign inst_pc    = inst_valid ? mem_pc[rd_ptr]   : {XLEN{1'b0}};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight after this cycle's response becomes stale.
      pc          <= redirect_base;
      rsp_pc      <= redirect_base;
      outstanding <= outstanding - cnt_t'(rsp_ok);
      drop        <= outstanding - cnt_t'(rsp_ok);
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      if (req_fire) pc <= pc + XLEN'(4);
      outstanding <= outstanding + cnt_t'(req_fire) - cnt_t'(rsp_ok);
      if (rsp_drop) drop <= drop - cnt_t'(1);
      if (push) begin
        rsp_pc <= rsp_pc + XLEN'(4);
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + cnt_t'(push) - cnt_t'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_inst[wr_ptr] <= imem_rsp_data;
      mem_pc[wr_ptr]   <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: an in-order memory model with random latency and an
// epoch-tagged reference of the decode stream, checked every cycle.
module tb_fetch_unit;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            imem_req_valid;
  logic            imem_req_ready = 1'b0;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid = 1'b0;
  logic [31:0]     imem_rsp_data = '0;
  logic            inst_valid;
  logic            inst_ready = 1'b0;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  // Clock / reset
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mem_req_t;

  mem_req_t    mem_q[$];   // accepted requests awaiting a response, in order
  logic [63:0] exp_q[$];   // expected decode entries {inst, pc}
  logic [31:0] exp_req_pc;
  int          epoch;
  int          useful;     // in-flight requests belonging to the current epoch
  int          cycle;
  int          rsp_epoch;
  logic [31:0] rsp_addr;
  int          checks;
  int          errors;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  task automatic do_reset();
    #1 reset_n = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    mem_q.delete();
    exp_q.delete();
    useful     = 0;
    epoch++;
    exp_req_pc = RESET_PC;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] tbl [4];
    int          k;
    tbl[0] = 32'h0000_0103;
    tbl[1] = 32'hFFFF_FFFC;
    tbl[2] = 32'hFFFF_FFF9;
    tbl[3] = 32'h8000_0040;
    k = $urandom_range(0, 4);
    return (k == 4) ? $urandom : tbl[k];
  endfunction

  // One clock cycle: drive at posedge+1, check and advance the model at posedge+4.
  task automatic step(input int rdy_pct, input int ird_pct, input int rd_pct, input int maxlat);
    mem_req_t    r;
    logic        fire;
    logic        do_pop;
    logic [63:0] head;
    @(posedge clock);
    #1;
    cycle++;
    imem_req_ready = ($urandom_range(0, 99) < rdy_pct);
    inst_ready     = ($urandom_range(0, 99) < ird_pct);
    redirect_valid = ($urandom_range(0, 99) < rd_pct);
    redirect_pc    = pick_target();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    rsp_epoch      = -1;
    if (mem_q.size() != 0 && mem_q[0].due <= cycle) begin
      r = mem_q.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(r.addr);
      rsp_epoch      = r.epoch;
      rsp_addr       = r.addr;
    end
    #3;

    check("inst_valid", inst_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check("inst_pc", inst_pc, head[31:0]);
      check("inst", inst, head[63:32]);
    end
    check("req_valid", imem_req_valid, !redirect_valid && (useful + exp_q.size() < DEPTH));
    if (imem_req_valid) check("req_addr", imem_req_addr, exp_req_pc);

    fire   = imem_req_valid && imem_req_ready;
    do_pop = inst_valid && inst_ready;
    if (redirect_valid) begin
      epoch++;
      exp_q.delete();
      useful     = 0;
      exp_req_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (do_pop && exp_q.size() != 0) void'(exp_q.pop_front());
      if (imem_rsp_valid && rsp_epoch == epoch) begin
        exp_q.push_back({mem_word(rsp_addr), rsp_addr});
        useful--;
      end
      if (fire) begin
        r.addr  = exp_req_pc;
        r.epoch = epoch;
        r.due   = cycle + $urandom_range(1, maxlat);
        if (mem_q.size() != 0 && r.due < mem_q[mem_q.size()-1].due)
          r.due = mem_q[mem_q.size()-1].due;
        mem_q.push_back(r);
        useful++;
        exp_req_pc = exp_req_pc + 32'd4;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cycle  = 0;
    epoch  = 0;
    do_reset();
    // Streaming, memory always ready with 1-cycle latency
    repeat (20) step(100, 100, 0, 1);
    // Decode stalled fills the FIFO, then resumes
    repeat (10) step(100, 0, 0, 1);
    repeat (10) step(100, 100, 0, 1);
    // Memory backpressure and longer latency
    repeat (60) step(30, 100, 0, 3);
    // Mixed traffic with redirects
    repeat (500) step(80, 60, 5, 3);
    repeat (300) step(100, 100, 25, 1);
    do_reset();
    repeat (500) step(50, 50, 10, 4);
    repeat (300) step(90, 30, 15, 2);
    do_reset();
    repeat (200) step(100, 100, 8, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
